// File: rtl/ms_pwm_dt_defs.sv
// rtl/ms_pwm_dt_defs.sv - shared state encodings and defaults for the PWM dead-time stage
package ms_pwm_dt_defs;

    localparam int DT_W_DEF = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DEAD_H = 3'd1;
    localparam logic [2:0] ST_HIGH   = 3'd2;
    localparam logic [2:0] ST_DEAD_L = 3'd3;
    localparam logic [2:0] ST_LOW    = 3'd4;
    localparam logic [2:0] ST_FAULT  = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        DEAD_H = ST_DEAD_H,
        HIGH   = ST_HIGH,
        DEAD_L = ST_DEAD_L,
        LOW    = ST_LOW,
        FAULT  = ST_FAULT
    } dt_state_e;

endpackage

// File: rtl/ms_pwm_deadtime.sv
// rtl/ms_pwm_deadtime.sv - complementary PWM drive with dead time and latched fault
module ms_pwm_deadtime
    import ms_pwm_dt_defs::*;
#(
    parameter int DT_W = DT_W_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dt_rise,
    input  logic [DT_W-1:0] dt_fall,
    input  logic            inv_h,
    input  logic            inv_l,
    input  logic            fault_i,
    input  logic            fault_clr,
    output logic            pwm_h,
    output logic            pwm_l,
    output logic            dead_o,
    output logic            fault_o,
    output logic            fault_flag
);

    localparam logic [DT_W-1:0] CNT_ONE = {{(DT_W-1){1'b0}}, 1'b1};

    dt_state_e       state_q, state_d;
    logic [DT_W-1:0] cnt_q, cnt_d;
    logic            pwm_q, pwm_d;
    logic            h_q, h_d;
    logic            l_q, l_d;
    logic            dead_q, dead_d;
    logic            fault_o_q, fault_o_d;
    logic            fault_flag_q, fault_flag_d;

    dt_state_e       rise_st, fall_st;
    logic [DT_W-1:0] rise_cnt, fall_cnt;

    // Entry targets for a new dead interval; a zero dead time skips straight to the drive state.
    always_comb begin
        rise_st  = (dt_rise == '0) ? HIGH : DEAD_H;
        rise_cnt = (dt_rise == '0) ? '0 : dt_rise - CNT_ONE;
        fall_st  = (dt_fall == '0) ? LOW : DEAD_L;
        fall_cnt = (dt_fall == '0) ? '0 : dt_fall - CNT_ONE;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pwm_d   = pwm_in;

        if (fault_i) begin
            state_d = FAULT;
            cnt_d   = '0;
        end else if (state_q == FAULT) begin
            if (fault_clr) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pwm_q) begin
                        state_d = rise_st;
                        cnt_d   = rise_cnt;
                    end else begin
                        state_d = fall_st;
                        cnt_d   = fall_cnt;
                    end
                end
                LOW: begin
                    if (pwm_q) begin
                        state_d = rise_st;
                        cnt_d   = rise_cnt;
                    end
                end
                HIGH: begin
                    if (!pwm_q) begin
                        state_d = fall_st;
                        cnt_d   = fall_cnt;
                    end
                end
                DEAD_H: begin
                    // A pulse shorter than the dead time is swallowed by heading back low.
                    if (!pwm_q) begin
                        state_d = fall_st;
                        cnt_d   = fall_cnt;
                    end else if (cnt_q == '0) begin
                        state_d = HIGH;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                DEAD_L: begin
                    if (pwm_q) begin
                        state_d = rise_st;
                        cnt_d   = rise_cnt;
                    end else if (cnt_q == '0) begin
                        state_d = LOW;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        h_d          = (state_d == HIGH);
        l_d          = (state_d == LOW);
        dead_d       = (state_d == DEAD_H) || (state_d == DEAD_L);
        fault_o_d    = (state_d == FAULT);
        fault_flag_d = fault_i && (state_q != FAULT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pwm_q        <= 1'b0;
            h_q          <= 1'b0;
            l_q          <= 1'b0;
            dead_q       <= 1'b0;
            fault_o_q    <= 1'b0;
            fault_flag_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pwm_q        <= pwm_d;
            h_q          <= h_d;
            l_q          <= l_d;
            dead_q       <= dead_d;
            fault_o_q    <= fault_o_d;
            fault_flag_q <= fault_flag_d;
        end
    end

    // Fault gating bypasses the flops so the gates turn off in the same cycle.
    assign pwm_h      = (h_q & ~fault_i) ^ inv_h;
    assign pwm_l      = (l_q & ~fault_i) ^ inv_l;
    assign dead_o     = dead_q;
    assign fault_o    = fault_o_q;
    assign fault_flag = fault_flag_q;

    assert property (@(posedge clk_i) disable iff (rst_i) !(h_q && l_q));

endmodule
